// File: rtl/simple_proc_ctrl.sv
// Multi-cycle control and datapath for the 9-bit simple processor:
// T0..T3 step sequencer driving a shared bus over R0-R7, A, G and IR.
module simple_proc_ctrl (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [8:0] DIN,
   input  logic       Run,
   output logic       Done,
   output logic [8:0] BusWires,
   input  logic [2:0] DbgSel,
   output logic [8:0] DbgData
);

   typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

   step_t      state, nstate;
   logic [8:0] ir;
   logic [8:0] a, g;
   logic [8:0] r [8];

   logic [2:0] op, rx, ry;
   logic       is_mv, is_mvi, is_arith, is_sub;

   logic       ir_ld, a_ld, g_ld, rx_wr;
   logic [8:0] bus;
   logic [8:0] addend, sum;

   assign op       = ir[8:6];
   assign rx       = ir[5:3];
   assign ry       = ir[2:0];
   assign is_mv    = (op == 3'b000);
   assign is_mvi   = (op == 3'b001);
   assign is_arith = (op[2:1] == 2'b01);
   assign is_sub   = ir[6];

   // Subtract as A + ~bus + 1; carry-out falls off the 9-bit result.
   assign addend = is_sub ? ~bus : bus;
   assign sum    = a + addend + {8'd0, is_sub};

   always_comb begin
      nstate = state;
      bus    = DIN;
      Done   = 1'b0;
      ir_ld  = 1'b0;
      a_ld   = 1'b0;
      g_ld   = 1'b0;
      rx_wr  = 1'b0;
      unique case (state)
         T0: begin
            if (Run) begin
               ir_ld  = 1'b1;
               nstate = T1;
            end
         end
         T1: begin
            unique case (1'b1)
               is_mv: begin
                  bus    = r[ry];
                  rx_wr  = 1'b1;
                  Done   = 1'b1;
                  nstate = T0;
               end
               is_mvi: begin
                  bus    = DIN;
                  rx_wr  = 1'b1;
                  Done   = 1'b1;
                  nstate = T0;
               end
               is_arith: begin
                  bus    = r[rx];
                  a_ld   = 1'b1;
                  nstate = T2;
               end
               default: begin
                  Done   = 1'b1;
                  nstate = T0;
               end
            endcase
         end
         T2: begin
            bus    = r[ry];
            g_ld   = 1'b1;
            nstate = T3;
         end
         T3: begin
            bus    = g;
            rx_wr  = 1'b1;
            Done   = 1'b1;
            nstate = T0;
         end
         default: nstate = T0;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= T0;
         ir    <= '0;
         a     <= '0;
         g     <= '0;
         for (int i = 0; i < 8; i++) r[i] <= '0;
      end else begin
         state <= nstate;
         if (ir_ld) ir <= DIN;
         if (a_ld)  a  <= bus;
         if (g_ld)  g  <= sum;
         if (rx_wr) r[rx] <= bus;
      end
   end

   assign BusWires = bus;
   assign DbgData  = r[DbgSel];

endmodule

// File: tb/tb_simple_proc_ctrl.sv
// Directed bench for simple_proc_ctrl: hand-computed bus, Done and
// register values over mvi/mv/add/sub/NOP, wrap-around and async reset.
module tb_simple_proc_ctrl;

   logic       Clock = 1'b0;
   logic       Reset;
   logic [8:0] DIN;
   logic       Run;
   logic       Done;
   logic [8:0] BusWires;
   logic [2:0] DbgSel;
   logic [8:0] DbgData;

   int nvec = 0;
   int nbad = 0;

   simple_proc_ctrl dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .DIN      (DIN),
      .Run      (Run),
      .Done     (Done),
      .BusWires (BusWires),
      .DbgSel   (DbgSel),
      .DbgData  (DbgData)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [8:0] obs,
                      input logic [8:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic reg_chk(input string tag, input logic [2:0] sel,
                          input logic [8:0] exp);
      DbgSel = sel;
      #1;
      chk(tag, DbgData, exp);
   endtask

   // Drive inputs just after the falling edge; sample 1 time unit later.
   task automatic cyc(input logic [8:0] din, input logic run);
      @(negedge Clock);
      DIN = din;
      Run = run;
      #1;
   endtask

   initial begin
      Reset  = 1'b1;
      DIN    = 9'h000;
      Run    = 1'b0;
      DbgSel = 3'd0;

      cyc(9'h1AB, 1'b0);
      chk("rst_done", {8'd0, Done}, 9'd0);
      chk("rst_bus", BusWires, 9'h1AB);
      reg_chk("rst_r0", 3'd0, 9'h000);
      @(negedge Clock);
      Reset = 1'b0;

      // mvi R0, 5
      cyc(9'h040, 1'b1);
      chk("mvi_t0_done", {8'd0, Done}, 9'd0);
      chk("mvi_t0_bus", BusWires, 9'h040);
      cyc(9'h005, 1'b0);
      chk("mvi_t1_done", {8'd0, Done}, 9'd1);
      chk("mvi_t1_bus", BusWires, 9'h005);

      // mv R1, R0
      cyc(9'h008, 1'b1);
      chk("mv_t0_done", {8'd0, Done}, 9'd0);
      reg_chk("mvi_r0", 3'd0, 9'h005);
      cyc(9'h000, 1'b0);
      chk("mv_t1_bus", BusWires, 9'h005);
      chk("mv_t1_done", {8'd0, Done}, 9'd1);

      // add R0, R1
      cyc(9'h081, 1'b1);
      reg_chk("mv_r1", 3'd1, 9'h005);
      reg_chk("mv_r0_keep", 3'd0, 9'h005);
      cyc(9'h000, 1'b0);
      chk("add_t1_bus", BusWires, 9'h005);
      chk("add_t1_done", {8'd0, Done}, 9'd0);
      cyc(9'h000, 1'b0);
      chk("add_t2_bus", BusWires, 9'h005);
      chk("add_t2_done", {8'd0, Done}, 9'd0);
      cyc(9'h000, 1'b0);
      chk("add_t3_bus", BusWires, 9'h00A);
      chk("add_t3_done", {8'd0, Done}, 9'd1);

      // sub R2, R0 : 0 - 10
      cyc(9'h0D0, 1'b1);
      chk("add_t0_done", {8'd0, Done}, 9'd0);
      reg_chk("add_r0", 3'd0, 9'h00A);
      cyc(9'h000, 1'b0);
      chk("sub_t1_bus", BusWires, 9'h000);
      cyc(9'h000, 1'b0);
      chk("sub_t2_bus", BusWires, 9'h00A);
      cyc(9'h000, 1'b0);
      chk("sub_t3_bus", BusWires, 9'h1F6);
      chk("sub_t3_done", {8'd0, Done}, 9'd1);

      // mvi R3, 0x1FF ; mvi R4, 1 ; add R3, R4 -> wraps to 0
      cyc(9'h058, 1'b1);
      reg_chk("sub_r2", 3'd2, 9'h1F6);
      cyc(9'h1FF, 1'b0);
      cyc(9'h060, 1'b1);
      reg_chk("mvi_r3", 3'd3, 9'h1FF);
      cyc(9'h001, 1'b0);
      cyc(9'h09C, 1'b1);
      reg_chk("mvi_r4", 3'd4, 9'h001);
      cyc(9'h000, 1'b0);
      cyc(9'h000, 1'b0);
      cyc(9'h000, 1'b0);
      chk("wrap_t3_bus", BusWires, 9'h000);
      chk("wrap_t3_done", {8'd0, Done}, 9'd1);
      cyc(9'h000, 1'b0);
      reg_chk("wrap_r3", 3'd3, 9'h000);

      // add R0, R1 interrupted by reset in T2
      cyc(9'h081, 1'b1);
      cyc(9'h000, 1'b0);
      @(negedge Clock);
      DIN   = 9'h155;
      Reset = 1'b1;
      #1;
      chk("midrst_done", {8'd0, Done}, 9'd0);
      chk("midrst_bus", BusWires, 9'h155);
      for (int i = 0; i < 8; i++)
         reg_chk($sformatf("midrst_r%0d", i), 3'(i), 9'h000);
      @(negedge Clock);
      Reset = 1'b0;
      cyc(9'h123, 1'b0);
      chk("idle_bus", BusWires, 9'h123);
      chk("idle_done", {8'd0, Done}, 9'd0);
      cyc(9'h0AB, 1'b0);
      chk("idle_bus2", BusWires, 9'h0AB);
      chk("idle_done2", {8'd0, Done}, 9'd0);

      // Run held high: mvi R6,0xAA ; NOP ; mv R5,R6 back to back
      cyc(9'h070, 1'b1);
      chk("b2b_t0_done", {8'd0, Done}, 9'd0);
      cyc(9'h0AA, 1'b1);
      chk("b2b_mvi_done", {8'd0, Done}, 9'd1);
      cyc(9'h140, 1'b1);
      chk("nop_t0_done", {8'd0, Done}, 9'd0);
      reg_chk("b2b_r6", 3'd6, 9'h0AA);
      cyc(9'h1C7, 1'b1);
      chk("nop_t1_done", {8'd0, Done}, 9'd1);
      chk("nop_t1_bus", BusWires, 9'h1C7);
      cyc(9'h02E, 1'b1);
      chk("mv2_t0_done", {8'd0, Done}, 9'd0);
      chk("mv2_t0_bus", BusWires, 9'h02E);
      reg_chk("nop_r0", 3'd0, 9'h000);
      reg_chk("nop_r6", 3'd6, 9'h0AA);
      cyc(9'h000, 1'b0);
      chk("mv2_t1_bus", BusWires, 9'h0AA);
      chk("mv2_t1_done", {8'd0, Done}, 9'd1);
      cyc(9'h000, 1'b0);
      reg_chk("mv2_r5", 3'd5, 9'h0AA);
      chk("end_done", {8'd0, Done}, 9'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/simple_proc_ctrl.md
# simple_proc_ctrl

Multi-cycle control and datapath for the 9-bit simple processor. It is the initiator side of the add/subtract datapath: it fetches instruction words from `DIN` under a `Run`/`Done` handshake and sequences the shared 9-bit bus through eight general registers (R0–R7) plus the A, G and IR registers. It performs mv, mvi, add and sub, with 9-bit wrap-around arithmetic. A debug read port exposes R0–R7 to the bench.

## Interface
- Parameters: none. Width is fixed at 9 bits by the IIIXXXYYY instruction format.
- `Clock`  in  1  rising-edge clock for all state.
- `Reset`  in  1  asynchronous, active-high; clears all state.
- `DIN`  in  9  instruction word, or immediate data during mvi T1.
- `Run`  in  1  start request, sampled only in T0.
- `Done`  out  1  high during the final step of an instruction (combinational from state/IR).
- `BusWires`  out  9  current value of the internal bus.
- `DbgSel`  in  3  register index for the debug read.
- `DbgData`  out  9  combinational read of R[DbgSel].

## Operation
- Instruction format: `DIN[8:6]`=III opcode, `[5:3]`=XXX (Rx, destination), `[2:0]`=YYY (Ry, source).
- Opcodes:
  - 000 mv: Rx←Ry
  - 001 mvi: Rx←next DIN word
  - 010 add: Rx←Rx+Ry
  - 011 sub: Rx←Rx−Ry
  - 100–111: NOP
- Step FSM states are T0, T1, T2, T3; registers are written on the rising edge at the end of a step.
- T0 (idle/fetch):
  - Bus=DIN.
  - If Run=1: IR←DIN, go to T1. Else stay in T0.
  - Done=0.
- mv T1: Bus=Ry; Rx←Bus; Done=1; →T0.
- mvi T1: Bus=DIN (the data word, held by the source this cycle); Rx←Bus; Done=1; →T0.
- NOP T1: Bus=DIN; no register write; Done=1; →T0.
- add/sub:
  - T1: Bus=Rx; A←Bus; →T2.
  - T2: Bus=Ry; G←A+Bus (add) or A+~Bus+1 (sub); →T3.
  - T3: Bus=G; Rx←Bus; Done=1; →T0.
- Arithmetic:
  - 9-bit two's-complement adder; carry-out discarded.
  - Subtraction inverts the bus operand and injects carry-in 1.
  - Results wrap modulo 512.
- x==y is legal:
  - mv R,R leaves R unchanged.
  - add R,R doubles R.
  - sub R,R gives 0.
- Run is ignored in T1–T3.
- With Run held high, the next instruction is fetched in the T0 cycle that immediately follows Done.
- A and G are internal only; they persist between instructions and are never cleared except by Reset.

## Timing
- Latency, T0 fetch cycle to the final write edge inclusive:
  - mv, mvi, NOP: 2 cycles.
  - add, sub: 4 cycles.
- The Rx update is visible on DbgData the cycle after Done is high.
- For mvi, DIN must carry the immediate during the cycle after the fetch.
- Reset, at any time including mid-instruction:
  - Immediately: R0–R7, A, G, IR ← 0 and state ← T0.
  - The partial instruction is abandoned with no write.
- Output values during and after reset:
  - Done=0.
  - BusWires=DIN (T0 selection).
  - DbgData=0 for every DbgSel.
- Release of Reset: the first fetch occurs on the first rising edge at which state is T0 and Run=1.
- Done is never high in T0. Done is high for exactly one cycle per instruction.

## Test plan
- Reset, then mvi R0 (DIN=0x040, Run=1), then data DIN=0x005 → Done high in T1; DbgSel=0 reads 0x005 next cycle; latency 2.
- mv R1,R0 (DIN=0x008) after the above → BusWires=0x005 in T1; R1=0x005; R0 unchanged.
- add R0,R1 (DIN=0x081) with R0=R1=5 → BusWires shows 0x005, 0x005, then 0x00A in T1/T2/T3; Done only in T3; R0=0x00A.
- sub R2,R0 (DIN=0x0D0) with R2=0, R0=0x00A → R2=0x1F6. Also: R3=0x1FF, R4=1, add R3,R4 → R3=0x000 (wrap, no flag).
- Reset asserted mid-T2 of an add → Done=0 and DbgData=0 for all regs in the same cycle; after release with Run=0 the FSM stays in T0; BusWires follows DIN.
- Opcode 101 (DIN=0x140), then Run held high with back-to-back mv → NOP gives Done in T1 with no register change; the next instruction is fetched the following cycle.
